// File: rtl/apb_master_bridge_pkg.sv
// Shared APB4 definitions: bridge FSM states and width helpers.
// Also used by the interconnect and the APB slaves.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // Number of PSTRB bits for a given data width.
  function automatic int strb_width(input int dw);
    return dw / 8;
  endfunction

  // Number of low address bits that must be zero for a full-width access.
  function automatic int align_bits(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Core request/response port plus APB4 master signals of the bridge.
interface apb_master_bridge_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  import apb_pkg::*;
  localparam int SW = strb_width(DW);

  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic          req_we_i;
  logic [DW-1:0] req_wdata_i;
  logic [SW-1:0] req_be_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic [AW-1:0] PADDR_o;
  logic [DW-1:0] PWDATA_o;
  logic          PWRITE_o;
  logic [SW-1:0] PSTRB_o;
  logic          PSEL_o;
  logic          PENABLE_o;
  logic [DW-1:0] PRDATA_i;
  logic          PREADY_i;
  logic          PSLVERR_i;

  // The bridge side.
  modport master (
    input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_be_i, rsp_ready_i,
           PRDATA_i, PREADY_i, PSLVERR_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           PADDR_o, PWDATA_o, PWRITE_o, PSTRB_o, PSEL_o, PENABLE_o
  );

  // Core plus APB slave side, as seen by whoever drives the bridge.
  modport slave (
    output req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_be_i, rsp_ready_i,
           PRDATA_i, PREADY_i, PSLVERR_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           PADDR_o, PWDATA_o, PWRITE_o, PSTRB_o, PSEL_o, PENABLE_o
  );
endinterface

// File: rtl/apb_master_bridge.sv
// valid/ready core port to APB4 master, one transfer in flight, with
// misalignment, PSLVERR and PREADY-timeout errors reported on the response.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_i,
  apb_master_bridge_if.master bus
);
  localparam int DW    = APB_DATA_WIDTH;
  localparam int AW    = APB_ADDR_WIDTH;
  localparam int SW    = strb_width(DW);
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [AW-1:0]    ALIGN_MASK = AW'((1 << align_bits(DW)) - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  apb_state_e     state, state_nxt;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  wdata_q;
  logic [SW-1:0]  strb_q;
  logic           we_q;
  logic [DW-1:0]  rdata_q;
  logic           err_q;
  logic [CNT_W-1:0] cnt_q;

  logic accept, misaligned, timeout;

  assign accept     = (state == ST_IDLE) && bus.req_valid_i;
  assign misaligned = |(bus.req_addr_i & ALIGN_MASK);
  // PREADY on the last allowed cycle still completes normally.
  assign timeout    = (TIMEOUT_CYCLES != 0) && !bus.PREADY_i && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.req_valid_i) state_nxt = misaligned ? ST_RESP : ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (bus.PREADY_i || timeout) state_nxt = ST_RESP;
      ST_RESP:   if (bus.rsp_ready_i) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready_o = (state == ST_IDLE);
    bus.PSEL_o      = (state == ST_SETUP) || (state == ST_ACCESS);
    bus.PENABLE_o   = (state == ST_ACCESS);
    bus.rsp_valid_o = (state == ST_RESP);
    bus.PADDR_o     = addr_q;
    bus.PWDATA_o    = wdata_q;
    bus.PSTRB_o     = strb_q;
    bus.PWRITE_o    = we_q;
    bus.rsp_rdata_o = rdata_q;
    bus.rsp_err_o   = err_q;
  end

  // Write data and strobes are zeroed at accept for reads, so the bus
  // outputs can come straight from the registers.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.req_addr_i;
        we_q    <= bus.req_we_i;
        wdata_q <= bus.req_we_i ? bus.req_wdata_i : '0;
        strb_q  <= bus.req_we_i ? bus.req_be_i : '0;
        cnt_q   <= '0;
        if (misaligned) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if (state == ST_ACCESS) begin
        if (bus.PREADY_i) begin
          rdata_q <= (!we_q && !bus.PSLVERR_i) ? bus.PRDATA_i : '0;
          err_q   <= bus.PSLVERR_i;
        end else begin
          cnt_q <= cnt_q + 1'b1;
          if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed table-driven bench for apb_master_bridge (TIMEOUT_CYCLES=4),
// with hand sequences for response back-pressure and mid-transfer reset.
module tb_apb_master_bridge;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  apb_master_bridge_if #(.DW(DW), .AW(AW)) bus ();

  apb_master_bridge #(
    .APB_DATA_WIDTH(DW),
    .APB_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_i(rst_i),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;   // ACCESS cycles with PREADY=0 before PREADY=1
    logic        slverr;
    logic [31:0] prdata;
    int          exp_lat;  // cycles from accept to rsp_valid
    logic        exp_apb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_strb;
    logic [31:0] exp_pwdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = 32'hFFFF_FFF0;
    bus.req_we_i    = 1'b1;
    bus.req_wdata_i = 32'h1111_1111;
    bus.req_be_i    = 4'hF;
    bus.rsp_ready_i = 1'b0;
    bus.PREADY_i    = 1'b0;
    bus.PSLVERR_i   = 1'b0;
    bus.PRDATA_i    = 32'h5A5A_5A5A;
  endtask

  // Issue one request, act as the APB slave, check bus and response.
  task automatic run(input vec_t v, input int idx, input int hold);
    int cyc, acc, psel_seen;
    string tag;
    tag = $sformatf("v%0d", idx);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = v.addr;
    bus.req_we_i    = v.we;
    bus.req_wdata_i = v.wdata;
    bus.req_be_i    = v.be;
    chk({tag, ".req_ready"}, 64'(bus.req_ready_o), 64'd1);
    step();
    // Change request inputs to prove the bridge latched them.
    idle_inputs();
    bus.req_valid_i = 1'b1;
    cyc = 1; acc = 0; psel_seen = 0;
    while (!bus.rsp_valid_o && cyc < 20) begin
      bus.PREADY_i  = 1'b0;
      bus.PSLVERR_i = 1'b0;
      bus.PRDATA_i  = 32'h5A5A_5A5A;
      if (bus.PSEL_o) begin
        psel_seen = 1;
        chk({tag, ".paddr"},  64'(bus.PADDR_o),  64'(v.addr));
        chk({tag, ".pwrite"}, 64'(bus.PWRITE_o), 64'(v.we));
        chk({tag, ".pstrb"},  64'(bus.PSTRB_o),  64'(v.exp_strb));
        chk({tag, ".pwdata"}, 64'(bus.PWDATA_o), 64'(v.exp_pwdata));
        if (cyc == 1) begin
          chk({tag, ".setup_penable"}, 64'(bus.PENABLE_o), 64'd0);
          // Slave signals must be ignored in SETUP.
          bus.PREADY_i  = 1'b1;
          bus.PSLVERR_i = 1'b1;
        end else begin
          chk({tag, ".access_penable"}, 64'(bus.PENABLE_o), 64'd1);
          if (acc == v.waits) begin
            bus.PREADY_i  = 1'b1;
            bus.PSLVERR_i = v.slverr;
            bus.PRDATA_i  = v.prdata;
          end
          acc++;
        end
      end
      step();
      cyc++;
    end
    bus.PREADY_i  = 1'b0;
    bus.PSLVERR_i = 1'b0;
    chk({tag, ".latency"},   64'(cyc), 64'(v.exp_lat));
    chk({tag, ".psel_seen"}, 64'(psel_seen), 64'(v.exp_apb));
    chk({tag, ".rdata"},     64'(bus.rsp_rdata_o), 64'(v.exp_rdata));
    chk({tag, ".err"},       64'(bus.rsp_err_o), 64'(v.exp_err));
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, ".hold_valid"}, 64'(bus.rsp_valid_o), 64'd1);
      chk({tag, ".hold_rdata"}, 64'(bus.rsp_rdata_o), 64'(v.exp_rdata));
      chk({tag, ".hold_err"},   64'(bus.rsp_err_o), 64'(v.exp_err));
      chk({tag, ".hold_ready"}, 64'(bus.req_ready_o), 64'd0);
      chk({tag, ".hold_psel"},  64'(bus.PSEL_o), 64'd0);
    end
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    step();
    bus.rsp_ready_i = 1'b0;
    chk({tag, ".rsp_drop"},   64'(bus.rsp_valid_o), 64'd0);
    chk({tag, ".back_idle"},  64'(bus.req_ready_o), 64'd1);
  endtask

  initial begin
    vecs[0] = '{32'h10, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'hDEAD_BEEF, 3, 1'b1, 32'hDEAD_BEEF, 1'b0, 4'h0, 32'h0};
    vecs[1] = '{32'h20, 1'b1, 32'hA5A5_0001, 4'b0011, 3, 1'b0, 32'hFFFF_FFFF, 6, 1'b1, 32'h0, 1'b0, 4'b0011, 32'hA5A5_0001};
    vecs[2] = '{32'h14, 1'b0, 32'h0, 4'h0, 0, 1'b1, 32'h0000_1234, 3, 1'b1, 32'h0, 1'b1, 4'h0, 32'h0};
    vecs[3] = '{32'h13, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0, 1, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0};
    vecs[4] = '{32'h40, 1'b0, 32'h0, 4'h0, 99, 1'b0, 32'h0, 6, 1'b1, 32'h0, 1'b1, 4'h0, 32'h0};
    vecs[5] = '{32'h44, 1'b0, 32'h0, 4'h0, 3, 1'b0, 32'hCAFE_0004, 6, 1'b1, 32'hCAFE_0004, 1'b0, 4'h0, 32'h0};
    vecs[6] = '{32'h22, 1'b1, 32'h1234_5678, 4'hF, 0, 1'b0, 32'h0, 1, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0};
    vecs[7] = '{32'h30, 1'b1, 32'h0BAD_F00D, 4'hF, 1, 1'b1, 32'h7777_7777, 4, 1'b1, 32'h0, 1'b1, 4'hF, 32'h0BAD_F00D};

    idle_inputs();
    rst_i = 1'b1;
    step();
    step();
    chk("rst.psel",      64'(bus.PSEL_o), 64'd0);
    chk("rst.penable",   64'(bus.PENABLE_o), 64'd0);
    chk("rst.rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst.rsp_err",   64'(bus.rsp_err_o), 64'd0);
    chk("rst.outs",      {bus.PADDR_o, bus.PWDATA_o}, 64'd0);
    chk("rst.misc",      64'({bus.PSTRB_o, bus.PWRITE_o, bus.rsp_rdata_o}), 64'd0);
    rst_i = 1'b0;
    step();
    chk("rst.req_ready", 64'(bus.req_ready_o), 64'd1);

    for (int i = 0; i < 8; i++) run(vecs[i], i, 0);

    // Response back-pressure for 5 cycles.
    run('{32'h18, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h1357_9BDF, 3, 1'b1, 32'h1357_9BDF, 1'b0, 4'h0, 32'h0}, 8, 5);

    // Reset pulsed during ACCESS with a stalled slave.
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h50;
    bus.req_we_i    = 1'b0;
    step();
    bus.req_valid_i = 1'b0;
    step();
    chk("rstmid.in_access", 64'(bus.PENABLE_o), 64'd1);
    rst_i = 1'b1;
    #1;
    chk("rstmid.psel",    64'(bus.PSEL_o), 64'd0);
    chk("rstmid.penable", 64'(bus.PENABLE_o), 64'd0);
    step();
    rst_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("rstmid.no_rsp", 64'({bus.rsp_valid_o, bus.PSEL_o}), 64'd0);
    end
    chk("rstmid.idle", 64'(bus.req_ready_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Converts a simple core-side valid/ready request/response port into APB4 master transfers. It sits directly upstream of the APB interconnect and drives the interconnect's single master port. One outstanding transfer at a time. Adds bus-error reporting for misaligned accesses, PSLVERR and slave timeout.

Parameters:
APB_DATA_WIDTH, 32, data width of PWDATA/PRDATA and request/response data (32 or 64)
APB_ADDR_WIDTH, 32, address width of PADDR and request address
TIMEOUT_CYCLES, 255, max ACCESS-phase cycles waiting for PREADY; 0 disables timeout

Ports:
clk  input  1  clock
rst_i  input  1  asynchronous, active-high reset
req_valid_i  input  1  request valid
req_ready_o  output  1  request accepted when valid&ready
req_addr_i  input  APB_ADDR_WIDTH  byte address
req_we_i  input  1  1 = write, 0 = read
req_wdata_i  input  APB_DATA_WIDTH  write data
req_be_i  input  APB_DATA_WIDTH/8  byte enables (write only)
rsp_valid_o  output  1  response valid, held until rsp_ready_i
rsp_ready_i  input  1  response consumed
rsp_rdata_o  output  APB_DATA_WIDTH  read data (0 on write or error)
rsp_err_o  output  1  error flag
PADDR_o  output  APB_ADDR_WIDTH  APB address
PWDATA_o  output  APB_DATA_WIDTH  APB write data
PWRITE_o  output  1  APB direction
PSTRB_o  output  APB_DATA_WIDTH/8  APB4 strobes
PSEL_o  output  1  APB select
PENABLE_o  output  1  APB enable
PRDATA_i  input  APB_DATA_WIDTH  APB read data
PREADY_i  input  1  APB ready
PSLVERR_i  input  1  APB slave error

Behaviour:
- Reset (async, rst_i=1): state IDLE; PSEL_o, PENABLE_o, rsp_valid_o, rsp_err_o = 0; PADDR_o, PWDATA_o, PSTRB_o, PWRITE_o, rsp_rdata_o = 0; timeout counter = 0. Reset mid-transfer drops PSEL/PENABLE immediately; the in-flight transfer is lost with no response.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready_o=1 (only in IDLE). On req_valid_i, latch addr/we/wdata/be.
  - Misaligned (addr low log2(DATA_WIDTH/8) bits != 0): go to RESP with err=1, rdata=0. No APB transfer.
  - Otherwise: go to SETUP.
- SETUP (1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB from latched values; next state ACCESS.
- ACCESS: PSEL=1, PENABLE=1, all APB outputs stable. Counter increments each cycle PREADY_i=0.
  - PREADY_i=1: capture rdata = read ? PRDATA_i : 0 and err = PSLVERR_i (on PSLVERR the read data is forced to 0). Next state RESP. PSEL/PENABLE are 0 next cycle.
  - Timeout (TIMEOUT_CYCLES!=0 and counter == TIMEOUT_CYCLES-1 with PREADY_i=0): abort, PSEL/PENABLE=0, err=1, rdata=0, next state RESP.
  - PREADY_i=1 on the timeout cycle: PREADY wins (normal completion).
- RESP: rsp_valid_o=1 with stable rdata/err until rsp_ready_i=1, then IDLE (rsp_valid_o=0 next cycle). Counter cleared on entering SETUP.
- PSTRB_o = 0 for reads (APB4 rule); PWDATA_o = 0 for reads.
- Latency with zero-wait slave: accept at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid at 3. Minimum 4 cycles between accepted requests with rsp_ready_i held at 1.
- Request inputs ignored outside IDLE. PREADY/PSLVERR/PRDATA ignored outside ACCESS.

Decomposition:
- apb_pkg: state enum (IDLE/SETUP/ACCESS/RESP), APB4 strobe-width function, alignment-mask helper. The package is shared with the interconnect and APB slaves.
- Single module; the timeout counter is inline. No sub-module is warranted.

Test Plan:
- Read at 0x0000_0010, slave PREADY=1, PRDATA=0xDEADBEEF -> PSEL at cycle 1, PENABLE at cycle 2, rsp_valid at cycle 3, rdata=0xDEADBEEF, err=0.
- Write 0xA5A5_0001 to 0x20 with be=4'b0011, 3 wait states -> PSTRB=0011 and PWDATA stable over 4 ACCESS cycles; rsp_valid 1 cycle after PREADY; rdata=0, err=0.
- Read with PREADY=1 and PSLVERR=1, PRDATA=0x1234 -> err=1, rdata=0.
- Read at addr 0x13 -> no PSEL ever asserted; rsp_valid at cycle 1 with err=1.
- TIMEOUT_CYCLES=4, PREADY stuck at 0 -> PSEL drops after 4 ACCESS cycles, err=1. Repeat with PREADY=1 on the 4th cycle -> normal response with err=0.
- rsp_ready_i=0 for 5 cycles -> rsp_valid and rdata held, req_ready_o=0. Separately, rst_i pulsed during ACCESS -> PSEL/PENABLE=0 the same cycle, no response, IDLE afterwards.
